// File: rtl/gray_counter_if.sv
// Control/status bundle for gray_counter: the count controls in, and the registered
// binary count, Gray count and wrap pulse out.
interface gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] Nbin;
    logic [WIDTH-1:0] Ngray;
    logic             wrap;

    modport master (output en, up, load, load_bin, input Nbin, Ngray, wrap);
    modport slave  (input en, up, load, load_bin, output Nbin, Ngray, wrap);
endinterface

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered reflected-Gray copy and a wrap pulse.
// Define GRAY_COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    gray_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

    logic [WIDTH-1:0] bin, gray, nxt;
    logic             wrap_q, nwrap;

    always_comb begin
        nxt   = bin;
        nwrap = 1'b0;
        if (bus.load) begin
            nxt = bus.load_bin;
        end else if (bus.en) begin
            if (bus.up) begin
                if (bin == MAXV) begin
                    nwrap = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
                    nxt   = bin;
`else
                    nxt   = '0;
`endif
                end else begin
                    nxt = bin + WIDTH'(1);
                end
            end else begin
                if (bin == '0) begin
                    nwrap = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
                    nxt   = bin;
`else
                    nxt   = MAXV;
`endif
                end else begin
                    nxt = bin - WIDTH'(1);
                end
            end
        end
    end

    // Gray is registered from the next binary value so it stays in step with bin
    // and is glitch-free at the output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bin    <= '0;
            gray   <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin    <= nxt;
            gray   <= nxt ^ (nxt >> 1);
            wrap_q <= nwrap;
        end
    end

    assign bus.Nbin  = bin;
    assign bus.Ngray = gray;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (WIDTH=4): directed sequences followed by
// random en/up/load traffic checked against an integer reference model.
module tb_gray_counter;
    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cnt    = 0;

    gray_counter_if #(.WIDTH(W)) bus ();
    gray_counter #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs across a rising edge, then check against the model.
    task automatic step(input logic e, input logic u, input logic l, input logic [W-1:0] lb);
        int   nc;
        logic w;
        int   pg;
        bus.en = e; bus.up = u; bus.load = l; bus.load_bin = lb;
        @(posedge clock); #1;
        w  = 1'b0;
        nc = cnt;
        if (l) nc = int'(lb);
        else if (e && u) begin
            if (cnt == MAXV) begin
                w = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
                nc = cnt;
`else
                nc = 0;
`endif
            end else nc = cnt + 1;
        end else if (e) begin
            if (cnt == 0) begin
                w = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
                nc = cnt;
`else
                nc = MAXV;
`endif
            end else nc = cnt - 1;
        end
        pg = cnt ^ (cnt >> 1);
        chk("nbin", 32'(bus.Nbin), 32'(nc));
        chk("ngray", 32'(bus.Ngray), 32'(nc ^ (nc >> 1)));
        chk("wrap", 32'(bus.wrap), 32'(w));
        chk("gray_match", 32'(bus.Ngray), 32'(bus.Nbin ^ (bus.Nbin >> 1)));
        if (e && !l && nc != cnt)
            chk("one_bit", 32'($countones(32'(bus.Ngray) ^ 32'(pg))), 32'd1);
        cnt = nc;
    endtask

    initial begin
        logic [W-1:0] gtab [17];
        gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        bus.en = 1'b0; bus.up = 1'b0; bus.load = 1'b0; bus.load_bin = '0;

        // Reset state
        @(posedge clock); #1;
        chk("rst_nbin", 32'(bus.Nbin), 0);
        chk("rst_ngray", 32'(bus.Ngray), 0);
        chk("rst_wrap", 32'(bus.wrap), 0);
        @(negedge clock); reset = 1'b0;
        cnt = 0;

        // Full up cycle, Gray sequence from a fixed table
        chk("g_seq0", 32'(bus.Ngray), 32'(gtab[0]));
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            chk("g_seq", 32'(bus.Ngray), 32'(gtab[i+1]));
            chk("g_wrap", 32'(bus.wrap), (i == 15) ? 32'd1 : 32'd0);
        end

        // Load 5 then two down steps
        step(1'b0, 1'b0, 1'b1, 4'h5);
        chk("ld5_bin", 32'(bus.Nbin), 32'h5); chk("ld5_gray", 32'(bus.Ngray), 32'h7);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("dn4_bin", 32'(bus.Nbin), 32'h4); chk("dn4_gray", 32'(bus.Ngray), 32'h6);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("dn3_bin", 32'(bus.Nbin), 32'h3); chk("dn3_gray", 32'(bus.Ngray), 32'h2);
        chk("dn3_wrap", 32'(bus.wrap), 0);

        // Down step from zero
        step(1'b0, 1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b0, 1'b0, '0);
`ifdef GRAY_COUNTER_SATURATE_EN
        chk("under_bin", 32'(bus.Nbin), 32'h0);
`else
        chk("under_bin", 32'(bus.Nbin), 32'hF);
        chk("under_gray", 32'(bus.Ngray), 32'h8);
`endif
        chk("under_wrap", 32'(bus.wrap), 1);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("hold_wrap", 32'(bus.wrap), 0);

        // Load wins over en at the top of the range
        step(1'b0, 1'b0, 1'b1, 4'hF);
        step(1'b1, 1'b1, 1'b1, 4'h2);
        chk("ldpri_bin", 32'(bus.Nbin), 32'h2); chk("ldpri_gray", 32'(bus.Ngray), 32'h3);
        chk("ldpri_wrap", 32'(bus.wrap), 0);

        // Asynchronous reset between edges, held across an edge with load/en active
        step(1'b0, 1'b0, 1'b1, 4'hA);
        #2 reset = 1'b1;
        #1;
        chk("arst_bin", 32'(bus.Nbin), 0);
        chk("arst_gray", 32'(bus.Ngray), 0);
        bus.en = 1'b1; bus.up = 1'b1; bus.load = 1'b1; bus.load_bin = 4'h7;
        @(posedge clock); #1;
        chk("arst_hold", 32'(bus.Nbin), 0);
        chk("arst_wrap", 32'(bus.wrap), 0);
        @(negedge clock); reset = 1'b0;
        cnt = 0;
        step(1'b1, 1'b1, 1'b0, '0);
        chk("post_rst", 32'(bus.Nbin), 32'h1);

        // Random traffic
        for (int i = 0; i < 1000; i++)
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), W'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
